// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller
// sitting between the MEM stage and a word-addressed data memory.
module dcache_ctrl #(
  parameter int unsigned NUM_LINES      = 8,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  output logic [31:0] RData,
  output logic        Stall,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic        MemWriteEnable,
  input  logic [31:0] MemReadData
);

  localparam int unsigned INDEX_BITS = $clog2(NUM_LINES);
  localparam int unsigned WORD_BITS  = $clog2(WORDS_PER_LINE);
  localparam int unsigned TAG_BITS   = 32 - INDEX_BITS - WORD_BITS - 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [WORD_BITS-1:0]   cnt_q;
  logic [NUM_LINES-1:0]   valid_q;
  logic [TAG_BITS-1:0]    tag_q  [NUM_LINES];
  logic [31:0]            data_q [NUM_LINES][WORDS_PER_LINE];

  logic [WORD_BITS-1:0]   word;
  logic [INDEX_BITS-1:0]  index;
  logic [TAG_BITS-1:0]    tag;
  logic                   hit;
  logic                   fill_last;
  logic                   read_miss;

  // Address decode and hit detection
  assign word      = Addr[WORD_BITS+1:2];
  assign index     = Addr[WORD_BITS+INDEX_BITS+1:WORD_BITS+2];
  assign tag       = Addr[31:WORD_BITS+INDEX_BITS+2];
  assign hit       = valid_q[index] && (tag_q[index] == tag);
  assign fill_last = (cnt_q == WORD_BITS'(WORDS_PER_LINE - 1));
  assign read_miss = !MemWrite && MemRead && !hit;

  // Next-state and memory-port / pipeline outputs
  always_comb begin
    state_d        = state_q;
    Stall          = 1'b0;
    MemWriteEnable = 1'b0;
    MemAddress     = Addr & ~32'h3;
    MemWriteData   = WData;
    RData          = hit ? data_q[index][word] : 32'h0;
    case (state_q)
      IDLE: begin
        if (MemWrite) begin
          Stall   = 1'b1;
          state_d = WRITE;
        end else if (read_miss) begin
          Stall   = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        Stall      = 1'b1;
        MemAddress = {tag, index, cnt_q, 2'b00};
        if (fill_last) state_d = IDLE;
      end
      WRITE: begin
        MemWriteEnable = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, fill counter and valid bits; reset aborts any fill in progress
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (read_miss) begin
            valid_q[index] <= 1'b0;
            cnt_q          <= '0;
          end
        end
        FILL: begin
          cnt_q <= cnt_q + WORD_BITS'(1);
          if (fill_last) valid_q[index] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Line data and tags: filled word by word, updated on store hits
  always_ff @(posedge CLK) begin
    if (RST) begin
      if (state_q == FILL) begin
        data_q[index][cnt_q] <= MemReadData;
        if (fill_last) tag_q[index] <= tag;
      end else if (state_q == WRITE && hit) begin
        data_q[index][word] <= WData;
      end
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: vector table driven through a
// scoreboard, plus a hand-written reset-during-fill sequence.
module tb_dcache_ctrl;

  logic        CLK;
  logic        RST;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic [31:0] RData;
  logic        Stall;
  logic [31:0] MemAddress;
  logic [31:0] MemWriteData;
  logic        MemWriteEnable;
  logic [31:0] MemReadData;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stalls;
    logic [31:0] rdata;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  vec_t sb[$];
  vec_t tbl[14];

  logic [31:0] mem [1024];

  dcache_ctrl #(.NUM_LINES(8), .WORDS_PER_LINE(4)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .Addr           (Addr),
    .WData          (WData),
    .RData          (RData),
    .Stall          (Stall),
    .MemAddress     (MemAddress),
    .MemWriteData   (MemWriteData),
    .MemWriteEnable (MemWriteEnable),
    .MemReadData    (MemReadData)
  );

  // Clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Data memory model: combinational read, write on posedge
  assign MemReadData = mem[MemAddress[11:2]];
  always @(posedge CLK) begin
    if (MemWriteEnable) mem[MemAddress[11:2]] <= MemWriteData;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one request, push its expectation, wait for completion and compare
  task automatic run_txn(input vec_t v);
    vec_t e;
    int   n;
    bit   done;
    MemRead  = v.rd;
    MemWrite = v.wr;
    Addr     = v.addr;
    WData    = v.wdata;
    sb.push_back(v);
    n    = 0;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge CLK);
      if (Stall) begin
        chk("we_during_stall", 32'(MemWriteEnable), 32'h0);
        if (!v.wr && n >= 1 && n <= 4)
          chk("fill_addr", MemAddress, {v.addr[31:4], 2'(n - 1), 2'b00});
        n++;
        @(posedge CLK); #1;
      end else begin
        done = 1'b1;
      end
    end
    e = sb.pop_front();
    if (!done) begin
      fails++;
      tests++;
      $display("FAIL timeout: addr %h still stalled after %0d cycles", e.addr, n);
    end
    chk("stall_cycles", 32'(n), 32'(e.stalls));
    if (e.wr) begin
      chk("write_we", 32'(MemWriteEnable), 32'h1);
      chk("write_addr", MemAddress, {e.addr[31:2], 2'b00});
      chk("write_data", MemWriteData, e.wdata);
    end else begin
      chk("read_data", RData, e.rdata);
    end
    @(posedge CLK); #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000 + 32'(i);

    tbl[0]  = '{1'b1, 1'b0, 32'h040, 32'h0,        5, 32'h1010};
    tbl[1]  = '{1'b1, 1'b0, 32'h048, 32'h0,        0, 32'h1012};
    tbl[2]  = '{1'b1, 1'b0, 32'h0C0, 32'h0,        5, 32'h1030};
    tbl[3]  = '{1'b1, 1'b0, 32'h040, 32'h0,        5, 32'h1010};
    tbl[4]  = '{1'b0, 1'b1, 32'h044, 32'hDEADBEEF, 1, 32'h0};
    tbl[5]  = '{1'b1, 1'b0, 32'h044, 32'h0,        0, 32'hDEADBEEF};
    tbl[6]  = '{1'b0, 1'b1, 32'h200, 32'h5A5A5A5A, 1, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, 32'h200, 32'h0,        5, 32'h5A5A5A5A};
    tbl[8]  = '{1'b1, 1'b0, 32'h04C, 32'h0,        0, 32'h1013};
    tbl[9]  = '{1'b0, 1'b1, 32'h300, 32'h11112222, 1, 32'h0};
    tbl[10] = '{1'b1, 1'b0, 32'h204, 32'h0,        0, 32'h1081};
    tbl[11] = '{1'b1, 1'b1, 32'h048, 32'h12345678, 1, 32'h0};
    tbl[12] = '{1'b1, 1'b0, 32'h048, 32'h0,        0, 32'h12345678};
    tbl[13] = '{1'b1, 1'b0, 32'h300, 32'h0,        5, 32'h11112222};

    RST      = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Addr     = 32'h0;
    WData    = 32'h0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;

    // Post-reset idle outputs
    @(negedge CLK);
    chk("reset_stall", 32'(Stall), 32'h0);
    chk("reset_we", 32'(MemWriteEnable), 32'h0);
    chk("reset_rdata", RData, 32'h0);
    @(posedge CLK); #1;

    // Table-driven requests, issued back to back
    for (int i = 0; i < 14; i++) run_txn(tbl[i]);
    MemRead  = 1'b0;
    MemWrite = 1'b0;

    chk("mem_word_11", mem[32'h11], 32'hDEADBEEF);
    chk("mem_word_12", mem[32'h12], 32'h12345678);
    chk("mem_word_80", mem[32'h80], 32'h5A5A5A5A);

    // Reset asserted during the second fill cycle of a read to 0x80
    @(posedge CLK); #1;
    MemRead = 1'b1;
    Addr    = 32'h80;
    @(negedge CLK);
    chk("rst_seq_idle_stall", 32'(Stall), 32'h1);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("rst_seq_fill0_addr", MemAddress, 32'h80);
    @(posedge CLK); #1;
    RST     = 1'b0;
    MemRead = 1'b0;
    @(negedge CLK);
    chk("rst_seq_fill1_addr", MemAddress, 32'h84);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(negedge CLK);
    chk("rst_seq_stall", 32'(Stall), 32'h0);
    chk("rst_seq_we", 32'(MemWriteEnable), 32'h0);
    chk("rst_seq_rdata", RData, 32'h0);
    @(posedge CLK); #1;
    run_txn('{1'b1, 1'b0, 32'h080, 32'h0, 5, 32'h1020});
    run_txn('{1'b1, 1'b0, 32'h040, 32'h0, 5, 32'h1010});
    run_txn('{1'b1, 1'b0, 32'h088, 32'h0, 0, 32'h1022});
    MemRead = 1'b0;

    @(negedge CLK);
    chk("final_idle_stall", 32'(Stall), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
